// File: rtl/feistel_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : feistel_round_engine
//  Description : Handshaked Feistel round engine for DES/3DES datapaths.
//                Loads one (L,R) block, runs ROUNDS rounds at one round per
//                clock using an external combinational f-function, and returns
//                the final halves with an optional final swap. Decryption
//                walks the subkey index in reverse order.
//  Revision    : 1.0  initial release
// ============================================================================
module feistel_round_engine #(
    parameter int HALF_W     = 32,
    parameter int ROUNDS     = 16,
    parameter int IDX_W      = 5,
    parameter int FINAL_SWAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [HALF_W-1:0] in_L,
    input  logic [HALF_W-1:0] in_R,
    output logic [IDX_W-1:0]  round_idx,
    output logic [HALF_W-1:0] f_in_R,
    input  logic [HALF_W-1:0] f_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HALF_W-1:0] out_L,
    output logic [HALF_W-1:0] out_R,
    output logic              busy
);

    // The round counter is one bit wider than the index so it can hold
    // ROUNDS itself even when ROUNDS == 2**IDX_W.
    localparam int               c_CW   = IDX_W + 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [HALF_W-1:0]  r_L;
    logic [HALF_W-1:0]  r_R;
    logic [c_CW-1:0]    r_rnd;
    logic               r_mode;
    logic               w_load;
    logic               w_step;
    logic [HALF_W-1:0]  w_res_L;
    logic [HALF_W-1:0]  w_res_R;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_rnd == c_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Block datapath: load on accept, one Feistel round per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_L    <= '0;
            r_R    <= '0;
            r_rnd  <= '0;
            r_mode <= 1'b0;
        end else if (w_load) begin
            r_L    <= in_L;
            r_R    <= in_R;
            r_rnd  <= '0;
            r_mode <= in_mode;
        end else if (w_step) begin
            r_L    <= r_R;
            r_R    <= r_L ^ f_out;
            r_rnd  <= r_rnd + c_CW'(1);
        end
    end

    // Decrypt mirrors the index; the subtraction wraps and is then truncated,
    // so the value outside RUN is simply whatever the counter implies.
    assign round_idx = r_mode ? IDX_W'(c_LAST - r_rnd) : IDX_W'(r_rnd);
    assign f_in_R    = r_R;

    generate
        if (FINAL_SWAP != 0) begin : g_swap
            assign w_res_L = r_R;
            assign w_res_R = r_L;
        end else begin : g_noswap
            assign w_res_L = r_L;
            assign w_res_R = r_R;
        end
    endgenerate

    // Result is only exposed while it is being offered.
    assign out_L = out_valid ? w_res_L : '0;
    assign out_R = out_valid ? w_res_R : '0;

endmodule
`default_nettype wire

// File: tb/tb_feistel_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feistel_round_engine
//  Description : Self-checking bench for feistel_round_engine (16-round DES
//                style instance plus a 3-round unswapped instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_feistel_round_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_L;
    logic [31:0] in_R;
    logic [4:0]  round_idx;
    logic [31:0] f_in_R;
    logic [31:0] f_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_L;
    logic [31:0] out_R;
    logic        busy;
    logic        f_zero;

    // Small instance: 3 rounds, no final swap, f tied to zero.
    logic        v5, rdy5, ov5, busy5, ordy5;
    logic [1:0]  idx5;
    logic [31:0] l5, r5, fin5, ol5, or5;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign f_out = f_zero ? 32'h0 : (f_in_R ^ ({27'd0, round_idx} * 32'h01010101));

    feistel_round_engine #(.HALF_W(32), .ROUNDS(16), .IDX_W(5), .FINAL_SWAP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_L(in_L), .in_R(in_R), .round_idx(round_idx),
        .f_in_R(f_in_R), .f_out(f_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_L(out_L), .out_R(out_R), .busy(busy)
    );

    feistel_round_engine #(.HALF_W(32), .ROUNDS(3), .IDX_W(2), .FINAL_SWAP(0)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5),
        .in_mode(1'b0), .in_L(l5), .in_R(r5), .round_idx(idx5),
        .f_in_R(fin5), .f_out(32'h0), .out_valid(ov5),
        .out_ready(ordy5), .out_L(ol5), .out_R(or5), .busy(busy5)
    );

    typedef struct {
        logic        mode;
        logic        fz;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: 16 DES-style rounds with the bench f, final swap.
    function automatic logic [63:0] model(input logic m, input logic [31:0] l0, input logic [31:0] r0);
        logic [31:0] l, r, t, k;
        l = l0;
        r = r0;
        for (int i = 0; i < 16; i++) begin
            k = (m ? 32'(15 - i) : 32'(i)) * 32'h01010101;
            t = l ^ (r ^ k);
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    // Present a block at a negedge and let the accept edge pass.
    task automatic start_block(input logic m, input logic [31:0] l, input logic [31:0] r);
        in_valid = 1'b1;
        in_mode  = m;
        in_L     = l;
        in_R     = r;
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_mode  = ~m;
        in_L     = $urandom;
        in_R     = $urandom;
    endtask

    // From the first RUN cycle: check index order and latency, capture result.
    task automatic finish_block(input logic m, output logic [31:0] ol, output logic [31:0] orr, input bit hs);
        for (int i = 0; i < 16; i++) begin
            check("round_idx", {59'd0, round_idx}, m ? 64'(15 - i) : 64'(i));
            check("run_no_valid", {63'd0, out_valid}, 64'd0);
            check("run_busy", {62'd0, busy, in_ready}, 64'd2);
            tick();
        end
        check("done_valid", {63'd0, out_valid}, 64'd1);
        ol  = out_L;
        orr = out_R;
        if (hs) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("after_hs", {61'd0, out_valid, busy, in_ready}, 64'd1);
        end
    endtask

    task automatic run_block(input logic m, input logic [31:0] l, input logic [31:0] r,
                             output logic [31:0] ol, output logic [31:0] orr);
        start_block(m, l, r);
        finish_block(m, ol, orr, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ol, orr, el, er, yl, yr;
        logic [63:0] exp_q [$];
        logic [63:0] e;
        int cyc, last_acc, n_acc, n_out;
        bit acc, outv, seen;

        vecs[0] = '{1'b0, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h01234567};
        vecs[1] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
        vecs[3] = '{1'b0, 1'b0, 32'h01234567, 32'h89ABCDEF, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'hCAFEF00D, 32'h12345678, 32'h0, 32'h0};
        for (int i = 3; i < 6; i++) begin
            {vecs[i].el, vecs[i].er} = model(vecs[i].mode, vecs[i].l, vecs[i].r);
        end

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_L = '0; in_R = '0;
        out_ready = 1'b0; f_zero = 1'b1;
        v5 = 1'b0; l5 = '0; r5 = '0; ordy5 = 1'b0;
        tick();
        check("rst_ready_valid_busy", {61'd0, in_ready, out_valid, busy}, 64'h4);
        check("rst_round_idx", {59'd0, round_idx}, 64'd0);
        check("rst_out", {out_L, out_R}, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_out", {out_L, out_R}, 64'd0);

        // Table vectors (T1 is entry 0).
        for (int i = 0; i < 6; i++) begin
            f_zero = vecs[i].fz;
            run_block(vecs[i].mode, vecs[i].l, vecs[i].r, ol, orr);
            check($sformatf("vec%0d_out", i), {ol, orr}, {vecs[i].el, vecs[i].er});
        end

        // T2: encrypt then decrypt returns the plaintext.
        f_zero = 1'b0;
        run_block(1'b0, 32'h13579BDF, 32'h2468ACE0, el, er);
        run_block(1'b1, el, er, ol, orr);
        check("t2_roundtrip", {ol, orr}, 64'h13579BDF_2468ACE0);

        // T3: stall in DONE while in_valid pulses.
        start_block(1'b0, 32'h11112222, 32'h33334444);
        finish_block(1'b0, ol, orr, 1'b0);
        check("t3_first", {ol, orr}, model(1'b0, 32'h11112222, 32'h33334444));
        yl = 32'h55556666;
        yr = 32'h77778888;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_mode  = 1'b1;
            in_L     = yl;
            in_R     = yr;
            check("t3_stable", {out_L, out_R}, {ol, orr});
            check("t3_hold", {62'd0, in_ready, out_valid}, 64'd1);
            tick();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("t3_not_taken", {63'd0, in_ready}, 64'd0);
        tick();
        out_ready = 1'b0;
        check("t3_idle", {61'd0, out_valid, busy, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_mode  = 1'b0;
        finish_block(1'b1, ol, orr, 1'b1);
        check("t3_second", {ol, orr}, model(1'b1, yl, yr));

        // T4: reset in the middle of a block.
        start_block(1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        for (int i = 0; i < 7; i++) tick();
        check("t4_idx7", {59'd0, round_idx}, 64'd7);
        rst = 1'b1;
        #1;
        check("t4_async", {61'd0, in_ready, out_valid, busy}, 64'h4);
        tick();
        rst = 1'b0;
        check("t4_rst_state", {61'd0, in_ready, out_valid, busy}, 64'h4);
        check("t4_rst_idx", {59'd0, round_idx}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        check("t4_no_output", {63'd0, seen}, 64'd0);
        run_block(1'b1, 32'h0BADF00D, 32'hFEEDFACE, ol, orr);
        check("t4_after", {ol, orr}, model(1'b1, 32'h0BADF00D, 32'hFEEDFACE));

        // T5: ROUNDS=3, no final swap.
        v5 = 1'b1; l5 = 32'hAAAA5555; r5 = 32'h0F0F0F0F;
        check("t5_ready", {63'd0, rdy5}, 64'd1);
        tick();
        v5 = 1'b0; l5 = '0; r5 = '0;
        for (int i = 0; i < 3; i++) begin
            check("t5_idx", {62'd0, idx5}, 64'(i));
            check("t5_run", {62'd0, ov5, busy5}, 64'd1);
            tick();
        end
        check("t5_valid", {63'd0, ov5}, 64'd1);
        check("t5_out", {ol5, or5}, 64'h0F0F0F0F_AAAA5555);
        ordy5 = 1'b1;
        tick();
        ordy5 = 1'b0;
        check("t5_idle", {61'd0, ov5, busy5, rdy5}, 64'd1);

        // T6: back-to-back blocks with out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_L      = 32'h00000001;
        in_R      = 32'h80000000;
        cyc = 0; last_acc = 0; n_acc = 0; n_out = 0;
        while (cyc < 150 && n_out < 4) begin
            acc  = in_valid && in_ready;
            outv = out_valid && out_ready;
            if (outv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL t6_spurious: got output %0h expected none", {out_L, out_R});
                end else begin
                    e = exp_q.pop_front();
                    check("t6_out", {out_L, out_R}, e);
                end
                n_out++;
            end
            if (acc) begin
                exp_q.push_back(model(in_mode, in_L, in_R));
                if (n_acc > 0) check("t6_interval", 64'(cyc - last_acc), 64'd18);
                last_acc = cyc;
                n_acc++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (n_acc < 4) begin
                    in_mode = ~in_mode;
                    in_L    = in_L * 32'd3 + 32'h1234;
                    in_R    = in_R ^ {in_L[15:0], in_L[31:16]};
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        check("t6_outputs", 64'(n_out), 64'd4);
        check("t6_accepts", 64'(n_acc), 64'd4);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
